// File: rtl/cpa_seq_adder_pkg.sv
// Shared types and constants for the chunked sequential carry-propagate adder.
// Holds the FSM state enum, the default slice width and the counter-width helper.
package cpa_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CPA_CHUNK = 8;

   // A one-chunk counter still needs one bit of storage.
   function automatic int clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cpa_seq_adder_if.sv
// Operand request / result handshake bundle for cpa_seq_adder.
// The master is the requester; the slave is the adder.
interface cpa_seq_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );
endinterface

// File: rtl/cpa_seq_adder_slice.sv
// Combinational CHUNK-bit generate/propagate ripple adder; the carry-in is
// folded into the bit-0 generate term so the ripple chain has no special case.
import cpa_seq_pkg::*;

module cpa_slice #(
   parameter int CHUNK = CPA_CHUNK
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK-1:0] w_g;
   logic [CHUNK-1:0] w_p;
   logic [CHUNK:0]   w_c;

   always_comb begin
      w_g    = a & b;
      w_p    = a ^ b;
      w_g[0] = w_g[0] | (w_p[0] & cin);
      w_c    = '0;
      w_c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      end
      sum  = w_p ^ w_c[CHUNK-1:0];
      cout = w_c[CHUNK];
   end

endmodule

// File: rtl/cpa_seq_adder.sv
// Wide add/subtract built from one narrow CPA slice, processed LSB chunk first,
// one chunk per cycle; result is held in DONE until the consumer takes it.
import cpa_seq_pkg::*;

module cpa_seq_adder #(
   parameter int WIDTH  = 32,
   parameter int CHUNK  = CPA_CHUNK,
   parameter int NCHUNK = WIDTH / CHUNK
) (
   input  logic               clk,
   input  logic               rst,
   cpa_seq_adder_if.slave     bus
);

   localparam int KW = clog2(NCHUNK);

   generate
      if (NCHUNK < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
         $error("cpa_seq_adder: WIDTH must be a multiple of CHUNK with at least two chunks");
      end
   endgenerate

   state_t                         r_state;
   logic [KW-1:0]                  r_k;
   logic                           r_carry;
   logic [NCHUNK-1:0][CHUNK-1:0]   r_a;
   logic [NCHUNK-1:0][CHUNK-1:0]   r_b;
   logic [NCHUNK-1:0][CHUNK-1:0]   r_sum;
   logic                           r_cout;
   logic                           r_ovf;
   logic                           r_in_ready;
   logic                           r_out_valid;
   logic                           r_busy;

   logic [CHUNK-1:0]               w_slice_sum;
   logic                           w_slice_cout;
   logic                           w_last;
   logic                           w_a_msb;
   logic                           w_b_msb;

   cpa_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (r_a[r_k]),
      .b    (r_b[r_k]),
      .cin  (r_carry),
      .sum  (w_slice_sum),
      .cout (w_slice_cout)
   );

   assign w_last  = (r_k == KW'(NCHUNK - 1));
   assign w_a_msb = r_a[NCHUNK-1][CHUNK-1];
   assign w_b_msb = r_b[NCHUNK-1][CHUNK-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_carry     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_a        <= bus.a;
                  r_b        <= bus.sub ? ~bus.b : bus.b;
                  r_carry    <= bus.sub;
                  r_k        <= '0;
                  r_state    <= RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            RUN: begin
               r_sum[r_k] <= w_slice_sum;
               r_carry    <= w_slice_cout;
               r_k        <= r_k + KW'(1);
               if (w_last) begin
                  // The MSB of the chunk being written is the result sign.
                  r_cout      <= w_slice_cout;
                  r_ovf       <= (w_a_msb == w_b_msb) && (w_slice_sum[CHUNK-1] != w_a_msb);
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = r_busy;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_cpa_seq_adder.sv
// Directed bench for cpa_seq_adder (WIDTH=32, CHUNK=8) with hand-computed results.
module tb_cpa_seq_adder;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   cpa_seq_adder_if #(.WIDTH(32)) bus ();

   cpa_seq_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction; hold = cycles to stall out_ready, poke = pulse in_valid during RUN.
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic ts, input logic [31:0] es, input logic ec, input logic eo,
                         input int hold, input bit poke);
      int lat;
      int w;
      w = 0;
      while (!bus.in_ready && w < 20) begin
         tick();
         w++;
      end
      chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
      bus.a        = ta;
      bus.b        = tb_v;
      bus.sub      = ts;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         if (poke && lat == 1) begin
            bus.a        = 32'hDEAD_BEEF;
            bus.in_valid = 1'b1;
         end
         if (poke && lat == 2) bus.in_valid = 1'b0;
         tick();
         lat++;
      end
      bus.in_valid = 1'b0;
      chk({tag, "_lat"}, 64'(lat), 64'd4);
      chk({tag, "_sum"}, 64'(bus.sum), 64'(es));
      chk({tag, "_cout"}, 64'(bus.cout), 64'(ec));
      chk({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({tag, "_hold_vld"}, 64'(bus.out_valid), 64'd1);
         chk({tag, "_hold_sum"}, 64'(bus.sum), 64'(es));
         chk({tag, "_hold_flags"}, 64'({bus.cout, bus.ovf}), 64'({ec, eo}));
         chk({tag, "_hold_inrdy"}, 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_drop_vld"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_idle_rdy"}, 64'(bus.in_ready), 64'd1);
      chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sub       = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_sum", 64'(bus.sum), 64'd0);
      chk("rst_flags", 64'({bus.cout, bus.ovf}), 64'd0);
      rst = 1'b0;
      tick();

      run_op("ripple",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0, 1'b0);
      run_op("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
      run_op("borrow",  32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b0);
      run_op("noborr",  32'd7,         32'd5,         1'b1, 32'h0000_0002, 1'b1, 1'b0, 0, 1'b0);
      run_op("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0);
      run_op("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
      run_op("bp",      32'h0F0F_0F0F, 32'h1010_1010, 1'b0, 32'h1F1F_1F1F, 1'b0, 1'b0, 3, 1'b1);

      // A pulse ignored in RUN must not produce a second result.
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("noextra_vld", 64'(bus.out_valid), 64'd0);
      end
      chk("noextra_busy", 64'(bus.busy), 64'd0);

      // Abort while chunk 2 is being processed.
      bus.a        = 32'hAAAA_AAAA;
      bus.b        = 32'h5555_5555;
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("mid_busy", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_vld", 64'(bus.out_valid), 64'd0);
      chk("abort_rdy", 64'(bus.in_ready), 64'd1);
      chk("abort_sum", 64'(bus.sum), 64'd0);
      chk("abort_busy", 64'(bus.busy), 64'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_noout", 64'(bus.out_valid), 64'd0);
      end

      run_op("after", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
